// File: rtl/reco_update_ctrl_pkg.sv
// Shared definitions for the update controller: FSM states, pipeline depth, epoch counter width.
// No logic of its own; it only supplies constants and types.
// Imported by the controller top and the address generator.
package reco_update_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   // Number of cycles from a buffer read to the matching result write.
   localparam int PIPE_LAT = 3;

   // Width of the completed-epoch counter and of the epoch count setting.
   localparam int EPOCH_W = 8;

endpackage

// File: rtl/reco_addr_gen.sv
// Element counters plus base-offset adders for read and write buffer addresses, wrapping at 2^addrWidth.
// Addresses are combinational from the counters; the counters advance one cycle after each step.
// No backpressure: rd_step/wr_step are honoured every cycle they are high.
module reco_addr_gen
   import reco_update_ctrl_pkg::*;
#(
   parameter int addrWidth = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 rd_step,
   input  logic                 wr_step,
   input  logic [addrWidth-1:0] len,
   input  logic [addrWidth-1:0] base_rd,
   input  logic [addrWidth-1:0] base_wr,
   output logic [addrWidth-1:0] rd_addr,
   output logic [addrWidth-1:0] wr_addr,
   output logic                 rd_last
);

   localparam logic [addrWidth-1:0] ONE = 1;

   logic [addrWidth-1:0] k_rd;
   logic [addrWidth-1:0] k_wr;

   // Read and write element indices; writes trail reads by the pipeline depth, so each has its own count.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         k_rd <= '0;
         k_wr <= '0;
      end else begin
         if (rd_step) k_rd <= k_rd + ONE;
         if (wr_step) k_wr <= k_wr + ONE;
      end
   end

   // Offsets added to the bases; the natural carry-out drop gives the wrap-around.
   always_comb begin
      rd_addr = base_rd + k_rd;
      wr_addr = base_wr + k_wr;
      rd_last = (k_rd == (len - ONE));
   end

endmodule

// File: rtl/reco_update_ctrl.sv
// Epoch-driven update controller: streams a buffer through an external datapath and writes results back.
// Latency: 3 cycles from rd_en to the matching wr_en; each epoch drains fully before the next starts.
// No backpressure: one element per cycle while running; abort/rst cancel the job on the next edge.
module reco_update_ctrl
   import reco_update_ctrl_pkg::*;
#(
   parameter int bitwidth      = 32,
   parameter int inputBitwidth = 16,
   parameter int addrWidth     = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [addrWidth-1:0]     cfg_len,
   input  logic [EPOCH_W-1:0]       cfg_epochs,
   input  logic [addrWidth-1:0]     cfg_base_rd,
   input  logic [addrWidth-1:0]     cfg_base_wr,
   input  logic [inputBitwidth-1:0] cfg_rate,
   input  logic [inputBitwidth-1:0] cfg_bias,
   input  logic [inputBitwidth-1:0] cfg_mu,
   output logic                     rd_en,
   output logic [addrWidth-1:0]     rd_addr,
   input  logic [bitwidth-1:0]      rd_data,
   output logic [bitwidth-1:0]      dp_data_in,
   output logic [inputBitwidth-1:0] dp_rate,
   output logic [inputBitwidth-1:0] dp_bias,
   output logic [inputBitwidth-1:0] dp_mu,
   output logic                     dp_valid,
   input  logic [bitwidth-1:0]      dp_data_out,
   output logic                     wr_en,
   output logic [addrWidth-1:0]     wr_addr,
   output logic [bitwidth-1:0]      wr_data,
   output logic                     busy,
   output logic                     done,
   output logic [EPOCH_W-1:0]       epoch_cnt
);

   localparam logic [EPOCH_W:0] EP_ONE = 1;

   state_t state, state_nx;

   logic [addrWidth-1:0]     len_q, base_rd_q, base_wr_q;
   logic [EPOCH_W-1:0]       epochs_q;
   logic [inputBitwidth-1:0] rate_q, bias_q, mu_q;

   // pipe_v[0]: rd_data present, pipe_v[1]: operand at datapath, pipe_v[PIPE_LAT-1]: result write.
   logic [PIPE_LAT-1:0] pipe_v;

   logic                 accept, clr, ep_inc, pipe_empty, rd_last;
   logic [EPOCH_W:0]     ep_next;
   logic [addrWidth-1:0] rd_addr_raw, wr_addr_raw;

   assign rd_en      = (state == RUN);
   assign busy       = (state == RUN) || (state == DRAIN);
   assign done       = (state == FIN);
   assign dp_valid   = pipe_v[1];
   assign wr_en      = pipe_v[PIPE_LAT-1];
   assign pipe_empty = (pipe_v == '0);
   assign ep_next    = {1'b0, epoch_cnt} + EP_ONE;

   // Addresses read as zero whenever their strobe is idle so the bus is quiet outside transfers.
   assign rd_addr = rd_en ? rd_addr_raw : '0;
   assign wr_addr = wr_en ? wr_addr_raw : '0;

   // Coefficients are only exposed to the datapath while a job is active.
   assign dp_rate = busy ? rate_q : '0;
   assign dp_bias = busy ? bias_q : '0;
   assign dp_mu   = busy ? mu_q   : '0;

   reco_addr_gen #(
      .addrWidth (addrWidth)
   ) u_addr_gen (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .rd_step (rd_en),
      .wr_step (wr_en),
      .len     (len_q),
      .base_rd (base_rd_q),
      .base_wr (base_wr_q),
      .rd_addr (rd_addr_raw),
      .wr_addr (wr_addr_raw),
      .rd_last (rd_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state plus job-control strobes; abort outranks everything else in busy states.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      clr      = 1'b0;
      ep_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
               clr    = 1'b1;
               if (cfg_len == '0 || cfg_epochs == '0) state_nx = FIN;
               else                                   state_nx = RUN;
            end
         end
         RUN: begin
            if (abort)        state_nx = IDLE;
            else if (rd_last) state_nx = DRAIN;
         end
         DRAIN: begin
            if (abort) begin
               state_nx = IDLE;
            end else if (pipe_empty) begin
               // Every write of this epoch has landed, so an in-place next epoch sees fresh data.
               ep_inc = 1'b1;
               if (ep_next < {1'b0, epochs_q}) begin
                  clr      = 1'b1;
                  state_nx = RUN;
               end else begin
                  state_nx = FIN;
               end
            end
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Config latch, epoch counter and the read->operand->write pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q      <= '0;
         base_rd_q  <= '0;
         base_wr_q  <= '0;
         epochs_q   <= '0;
         rate_q     <= '0;
         bias_q     <= '0;
         mu_q       <= '0;
         epoch_cnt  <= '0;
         pipe_v     <= '0;
         dp_data_in <= '0;
         wr_data    <= '0;
      end else begin
         if (accept) begin
            len_q     <= cfg_len;
            base_rd_q <= cfg_base_rd;
            base_wr_q <= cfg_base_wr;
            epochs_q  <= cfg_epochs;
            rate_q    <= cfg_rate;
            bias_q    <= cfg_bias;
            mu_q      <= cfg_mu;
            epoch_cnt <= '0;
         end else if (ep_inc) begin
            epoch_cnt <= ep_next[EPOCH_W-1:0];
         end
         if (busy && abort) pipe_v <= '0;
         else               pipe_v <= {pipe_v[PIPE_LAT-2:0], rd_en};
         if (pipe_v[0]) dp_data_in <= rd_data;
         if (pipe_v[1]) wr_data    <= dp_data_out;
      end
   end

endmodule

// File: tb/tb_reco_update_ctrl.sv
// Directed bench for reco_update_ctrl with a buffer model and a multiply-by-rate datapath model.
// Expected reads/writes are queued by the stimulus and popped by an independent negedge monitor.
// Timing-related expectations are checked against cycles counted from the start edge.
module tb_reco_update_ctrl;

   logic        clk, rst, start, abort;
   logic [9:0]  cfg_len, cfg_base_rd, cfg_base_wr;
   logic [7:0]  cfg_epochs;
   logic [15:0] cfg_rate, cfg_bias, cfg_mu;
   logic        rd_en, dp_valid, wr_en, busy, done;
   logic [9:0]  rd_addr, wr_addr;
   logic [31:0] rd_data, dp_data_in, dp_data_out, wr_data;
   logic [15:0] dp_rate, dp_bias, dp_mu;
   logic [7:0]  epoch_cnt;

   logic [31:0] mem [0:1023];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t0 = 0;
   int rd_cyc[$];
   int wr_cyc[$];
   int done_cnt = 0;
   int done_rel = -1;
   bit busy_seen = 0;
   logic [9:0]  exp_rd[$];
   logic [9:0]  exp_wa[$];
   logic [31:0] exp_wd[$];

   reco_update_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_len(cfg_len), .cfg_epochs(cfg_epochs),
      .cfg_base_rd(cfg_base_rd), .cfg_base_wr(cfg_base_wr),
      .cfg_rate(cfg_rate), .cfg_bias(cfg_bias), .cfg_mu(cfg_mu),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .dp_data_in(dp_data_in), .dp_rate(dp_rate), .dp_bias(dp_bias), .dp_mu(dp_mu),
      .dp_valid(dp_valid), .dp_data_out(dp_data_out),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .epoch_cnt(epoch_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // External datapath: operand times rate.
   assign dp_data_out = dp_data_in * {16'h0, dp_rate};

   // Buffer model: read data one cycle after rd_en, junk otherwise; writes land on the edge.
   always @(posedge clk) begin
      if (rd_en === 1'b1) rd_data <= mem[rd_addr];
      else                rd_data <= 32'hDEAD_BEEF;
      if (wr_en === 1'b1) mem[wr_addr] <= wr_data;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: compares every read/write the DUT presents against the queued expectations.
   always @(negedge clk) begin
      if (rd_en === 1'b1) begin
         rd_cyc.push_back(cyc - t0);
         if (exp_rd.size() == 0) begin
            checks++; failures++;
            $display("FAIL rd_unexpected actual_addr=%0d expected=none", rd_addr);
         end else begin
            chk("rd_addr", 64'(rd_addr), 64'(exp_rd.pop_front()));
         end
      end
      if (wr_en === 1'b1) begin
         wr_cyc.push_back(cyc - t0);
         if (exp_wa.size() == 0) begin
            checks++; failures++;
            $display("FAIL wr_unexpected actual_addr=%0d data=%0h expected=none", wr_addr, wr_data);
         end else begin
            chk("wr_addr", 64'(wr_addr), 64'(exp_wa.pop_front()));
            chk("wr_data", 64'(wr_data), 64'(exp_wd.pop_front()));
         end
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_rel = cyc - t0;
      end
      if (busy === 1'b1) busy_seen = 1'b1;
   end

   task automatic exp_r(input int a);
      exp_rd.push_back(10'(a));
   endtask

   task automatic exp_w(input int a, input int d);
      exp_wa.push_back(10'(a));
      exp_wd.push_back(32'(d));
   endtask

   task automatic launch(input int len, input int ep, input int brd, input int bwr,
                         input int rate, input logic ab);
      @(negedge clk);
      rd_cyc.delete();
      wr_cyc.delete();
      done_cnt    = 0;
      done_rel    = -1;
      busy_seen   = 1'b0;
      cfg_len     = 10'(len);
      cfg_epochs  = 8'(ep);
      cfg_base_rd = 10'(brd);
      cfg_base_wr = 10'(bwr);
      cfg_rate    = 16'(rate);
      start       = 1'b1;
      abort       = ab;
      t0          = cyc;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s_timeout actual=no_done expected=done_within_%0d", name, budget);
      end
      @(negedge clk);
   endtask

   task automatic queues_empty(input string name);
      chk({name, "_rd_left"}, 64'(exp_rd.size()), 64'd0);
      chk({name, "_wr_left"}, 64'(exp_wa.size()), 64'd0);
   endtask

   task automatic outs_zero(input string name);
      chk({name, "_ctl"},  {51'h0, rd_en, dp_valid, wr_en, busy, done, epoch_cnt}, 64'd0);
      chk({name, "_addr"}, {44'h0, rd_addr, wr_addr}, 64'd0);
      chk({name, "_data"}, {wr_data, dp_data_in}, 64'd0);
      chk({name, "_coef"}, {16'h0, dp_rate, dp_bias, dp_mu}, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=stalled expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      cfg_len = '0; cfg_epochs = '0; cfg_base_rd = '0; cfg_base_wr = '0;
      cfg_rate = '0; cfg_bias = 16'h1234; cfg_mu = 16'h00AB;
      for (int i = 0; i < 1024; i++) mem[i] = 32'(i + 1);
      repeat (3) @(negedge clk);
      outs_zero("reset");
      rst = 1'b0;

      // Basic single epoch, identity datapath.
      for (int i = 0; i < 4; i++) begin
         exp_r(i);
         exp_w(16 + i, i + 1);
      end
      launch(4, 1, 0, 16, 1, 1'b0);
      chk("s1_busy", 64'(busy), 64'd1);
      chk("s1_bias", 64'(dp_bias), 64'h1234);
      chk("s1_mu", 64'(dp_mu), 64'h00AB);
      wait_done("s1", 40);
      chk("s1_rd_n", 64'(rd_cyc.size()), 64'd4);
      chk("s1_rd_first", 64'(rd_cyc[0]), 64'd1);
      chk("s1_rd_last", 64'(rd_cyc[3]), 64'd4);
      chk("s1_wr_first", 64'(wr_cyc[0]), 64'd4);
      chk("s1_wr_last", 64'(wr_cyc[3]), 64'd7);
      chk("s1_done_n", 64'(done_cnt), 64'd1);
      chk("s1_epoch", 64'(epoch_cnt), 64'd1);
      chk("s1_idle_rate", {busy, dp_rate}, 64'd0);
      queues_empty("s1");

      // Two epochs in place, datapath multiplies by 2.
      @(negedge clk);
      mem[5] = 32'd1; mem[6] = 32'd2; mem[7] = 32'd3;
      for (int i = 0; i < 3; i++) exp_r(5 + i);
      for (int i = 0; i < 3; i++) exp_r(5 + i);
      exp_w(5, 2); exp_w(6, 4); exp_w(7, 6);
      exp_w(5, 4); exp_w(6, 8); exp_w(7, 12);
      launch(3, 2, 5, 5, 2, 1'b0);
      chk("s2_rate", 64'(dp_rate), 64'd2);
      wait_done("s2", 80);
      chk("s2_epoch", 64'(epoch_cnt), 64'd2);
      chk("s2_done_n", 64'(done_cnt), 64'd1);
      chk("s2_raw_order", 64'(rd_cyc[3] > wr_cyc[2]), 64'd1);
      chk("s2_mem5", 64'(mem[5]), 64'd4);
      chk("s2_mem6", 64'(mem[6]), 64'd8);
      chk("s2_mem7", 64'(mem[7]), 64'd12);
      queues_empty("s2");

      // Read address wraps past the top of the buffer.
      exp_r(1022); exp_r(1023); exp_r(0); exp_r(1);
      exp_w(100, 1023); exp_w(101, 1024); exp_w(102, 1); exp_w(103, 2);
      launch(4, 1, 1022, 100, 1, 1'b0);
      wait_done("s3", 40);
      chk("s3_done_n", 64'(done_cnt), 64'd1);
      queues_empty("s3");

      // Zero length: straight to FIN; a start during FIN is dropped.
      launch(0, 3, 0, 0, 1, 1'b0);
      cfg_len = 10'd2; cfg_epochs = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("s4a_busy_seen", 64'(busy_seen), 64'd0);
      chk("s4a_done_n", 64'(done_cnt), 64'd1);
      chk("s4a_done_rel", 64'(done_rel), 64'd1);
      chk("s4a_epoch", 64'(epoch_cnt), 64'd0);

      // Zero epochs.
      launch(5, 0, 0, 0, 1, 1'b0);
      repeat (3) @(negedge clk);
      chk("s4b_busy_seen", 64'(busy_seen), 64'd0);
      chk("s4b_done_n", 64'(done_cnt), 64'd1);
      chk("s4b_done_rel", 64'(done_rel), 64'd1);
      queues_empty("s4");

      // Abort two cycles into a run; a start alongside it is ignored.
      exp_r(200); exp_r(201);
      launch(8, 1, 200, 300, 1, 1'b0);
      @(negedge clk);
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      chk("s5_busy_after_abort", 64'(busy), 64'd0);
      repeat (8) @(negedge clk);
      chk("s5_no_writes", 64'(wr_cyc.size()), 64'd0);
      chk("s5_no_done", 64'(done_cnt), 64'd0);
      chk("s5_epoch_held", 64'(epoch_cnt), 64'd0);
      // Restart with abort also high while idle: start must win.
      exp_r(200); exp_r(201);
      exp_w(300, 201); exp_w(301, 202);
      launch(2, 1, 200, 300, 1, 1'b1);
      wait_done("s5b", 40);
      chk("s5b_done_n", 64'(done_cnt), 64'd1);
      chk("s5b_epoch", 64'(epoch_cnt), 64'd1);
      queues_empty("s5");

      // Start while busy with different config is ignored.
      for (int i = 0; i < 4; i++) begin
         exp_r(i);
         exp_w(400 + i, i + 1);
      end
      launch(4, 1, 0, 400, 1, 1'b0);
      @(negedge clk);
      cfg_len = 10'd1; cfg_base_wr = 10'd500; cfg_rate = 16'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("s6a", 40);
      chk("s6a_done_n", 64'(done_cnt), 64'd1);
      chk("s6a_epoch", 64'(epoch_cnt), 64'd1);
      queues_empty("s6a");

      // Reset in the middle of DRAIN.
      for (int i = 0; i < 4; i++) exp_r(i);
      for (int i = 0; i < 3; i++) exp_w(410 + i, i + 1);
      launch(4, 1, 0, 410, 1, 1'b0);
      chk("s6b_epoch_cleared", 64'(epoch_cnt), 64'd0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      outs_zero("midrst");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("s6b_no_done", 64'(done_cnt), 64'd0);
      chk("s6b_idle", 64'(busy), 64'd0);
      queues_empty("s6b");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
